tx_pulse_scheduler: RTL and testbench

- Downstream of the Transmitter delay calculation.
- Accepts one integer delay per transducer element (in clk cycles) over a serial load interface.
- On fire, emits a PULSE_LEN-cycle transmit pulse on each element's txArray bit, scheduled relative to the smallest loaded delay, then signals done.
- Converts the per-focal-point delay set into the physical 64-bit transmit vector for one scan point.

---
 rtl/tx_pulse_scheduler.sv | 145 ++++++++++++++
 tb/tb_tx_pulse_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pulse_scheduler.sv
// rtl/tx_pulse_scheduler.sv - per-element delay load and transmit pulse scheduling for one scan point
// Optional feature macro: TX_APODIZATION_EN (adds tx_mask, per-element transmit enable sampled at fire)
module tx_pulse_scheduler #(
  parameter int NUM_ELEM  = 64,
  parameter int IDX_DW    = 6,
  parameter int DELAY_DW  = 18,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [IDX_DW-1:0]   load_idx,
  input  logic [DELAY_DW-1:0] load_delay,
  output logic                load_err,
  output logic                armed,
  input  logic                fire,
`ifdef TX_APODIZATION_EN
  input  logic [NUM_ELEM-1:0] tx_mask,
`endif
  output logic                busy,
  output logic [NUM_ELEM-1:0] txArray,
  output logic                done
);

  // One extra bit so delay + PULSE_LEN never wraps for the largest legal delay.
  localparam int CW = DELAY_DW + 1;

  typedef enum logic [1:0] {S_LOAD, S_ARMED, S_FIRE} state_t;

  state_t              state, state_n;
  logic [DELAY_DW-1:0] delay_mem [NUM_ELEM];
  logic [NUM_ELEM-1:0] loaded;
  logic [NUM_ELEM-1:0] mask_q;
  logic [NUM_ELEM-1:0] sel;
  logic [NUM_ELEM-1:0] tx_n;
  logic [DELAY_DW-1:0] min_d, max_d;
  logic [CW-1:0]       cnt, now, span_end;
  logic                wr_ok, wr_new, fire_go, fire_end;

  // Absolute time relative to the earliest element, and the cycle on which the last pulse ends.
  assign now      = cnt + CW'(min_d);
  assign span_end = CW'(max_d) - CW'(min_d) + CW'(PULSE_LEN);
  assign sel      = wr_new ? (NUM_ELEM'(1) << load_idx) : '0;

  // Next-state and transaction decode.
  always_comb begin
    state_n  = state;
    wr_ok    = 1'b0;
    wr_new   = 1'b0;
    fire_go  = 1'b0;
    fire_end = 1'b0;
    case (state)
      S_LOAD: begin
        wr_ok  = load_valid;
        wr_new = load_valid && !loaded[load_idx];
        if (&(loaded | sel)) state_n = S_ARMED;
      end
      S_ARMED: begin
        if (fire) begin
          fire_go = 1'b1;
          state_n = S_FIRE;
        end
      end
      S_FIRE: begin
        if (cnt == span_end) begin
          fire_end = 1'b1;
          state_n  = S_LOAD;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  // Per-element pulse window: high while now is in [d_n, d_n + PULSE_LEN).
  always_comb begin
    tx_n = '0;
    for (int n = 0; n < NUM_ELEM; n++) begin
      tx_n[n] = (state == S_FIRE) && !fire_end && mask_q[n] &&
                (now >= CW'(delay_mem[n])) &&
                (now < CW'(delay_mem[n]) + CW'(PULSE_LEN));
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  // Delay storage; contents are only meaningful where the loaded bitmap is set.
  always_ff @(posedge clk) begin
    if (wr_new) delay_mem[load_idx] <= load_delay;
  end

  // Loaded bitmap and running min/max, cleared at the end of every transmit.
  always_ff @(posedge clk) begin
    if (rst || fire_end) begin
      loaded <= '0;
      min_d  <= '1;
      max_d  <= '0;
    end else if (wr_new) begin
      loaded[load_idx] <= 1'b1;
      if (load_delay < min_d) min_d <= load_delay;
      if (load_delay > max_d) max_d <= load_delay;
    end
  end

  // Transmit cycle counter, zeroed on the fire edge.
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (fire_go)         cnt <= '0;
    else if (state == S_FIRE) cnt <= cnt + 1'b1;
  end

`ifdef TX_APODIZATION_EN
  // Apodization mask captured at the fire edge and held for the whole transmit.
  always_ff @(posedge clk) begin
    if (rst)          mask_q <= '1;
    else if (fire_go) mask_q <= tx_mask;
  end
`else
  assign mask_q = '1;
`endif

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_ready <= 1'b1;
      load_err   <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      txArray    <= '0;
      done       <= 1'b0;
    end else begin
      load_ready <= (state_n == S_LOAD);
      load_err   <= wr_ok && !wr_new;
      armed      <= (state_n == S_ARMED) || (state_n == S_FIRE);
      busy       <= (state_n == S_FIRE);
      txArray    <= tx_n;
      done       <= fire_end;
    end
  end

endmodule

// File: tb/tb_tx_pulse_scheduler.sv
// tb/tb_tx_pulse_scheduler.sv - directed self-checking bench for tx_pulse_scheduler
module tb_tx_pulse_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [5:0]  load_idx = '0;
  logic [17:0] load_delay = '0;
  logic        load_err;
  logic        armed;
  logic        fire = 1'b0;
  logic [63:0] tx_mask = '1;
  logic        busy;
  logic [63:0] txArray;
  logic        done;

  int total = 0;
  int bad = 0;
  int rise [64];
  int fall [64];
  int pulses [64];
  int done_k;
  int done_cnt;

  always #5 clk = ~clk;

  tx_pulse_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_idx   (load_idx),
    .load_delay (load_delay),
    .load_err   (load_err),
    .armed      (armed),
    .fire       (fire),
`ifdef TX_APODIZATION_EN
    .tx_mask    (tx_mask),
`endif
    .busy       (busy),
    .txArray    (txArray),
    .done       (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int idx, input int d);
    @(negedge clk);
    load_valid = 1'b1;
    load_idx   = 6'(idx);
    load_delay = 18'(d);
  endtask

  task automatic wr_end();
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge just after edge T0.
  task automatic do_fire();
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
  endtask

  // Observes edges T0+1 .. until three edges past done, or max_k edges.
  task automatic watch(input int max_k);
    logic [63:0] prev;
    prev     = '0;
    done_k   = -1;
    done_cnt = 0;
    for (int n = 0; n < 64; n++) begin
      rise[n] = -1; fall[n] = -1; pulses[n] = 0;
    end
    for (int k = 1; k <= max_k; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int n = 0; n < 64; n++) begin
        if (txArray[n] && !prev[n]) begin
          pulses[n]++;
          if (rise[n] < 0) rise[n] = k;
        end
        if (!txArray[n] && prev[n] && fall[n] < 0) fall[n] = k;
      end
      prev = txArray;
      if (done) begin
        done_cnt++;
        done_k = k;
      end
      if (done_k > 0 && k >= done_k + 3) break;
    end
  endtask

  function automatic logic [63:0] once_vec();
    logic [63:0] v;
    for (int n = 0; n < 64; n++) v[n] = (pulses[n] == 1);
    return v;
  endfunction

  initial begin
    int dn;
    // Reset state.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_load_ready", 64'(load_ready), 64'd1);
    check("rst_armed",      64'(armed),      64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_tx",         txArray,         64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_load_err",   64'(load_err),   64'd0);

    // Flat delays: all elements pulse together for PULSE_LEN cycles.
    for (int n = 0; n < 64; n++) wr(n, 100);
    wr_end();
    check("flat_armed",      64'(armed),      64'd1);
    check("flat_load_ready", 64'(load_ready), 64'd0);
    wr(3, 7);
    wr_end();
    check("armed_wr_no_err", 64'(load_err), 64'd0);
    do_fire();
    check("flat_busy_t0", 64'(busy), 64'd1);
    watch(50);
    check("flat_rise0",  64'(rise[0]),  64'd1);
    check("flat_fall0",  64'(fall[0]),  64'd5);
    check("flat_rise3",  64'(rise[3]),  64'd1);
    check("flat_fall63", 64'(fall[63]), 64'd5);
    check("flat_done_k", 64'(done_k),   64'd5);
    check("flat_done_n", 64'(done_cnt), 64'd1);
    check("flat_once",   once_vec(),    '1);
    check("flat_busy_end",  64'(busy),       64'd0);
    check("flat_ready_end", 64'(load_ready), 64'd1);
    check("flat_armed_end", 64'(armed),      64'd0);

    // Duplicate write is rejected and the first value is kept.
    wr(5, 50);
    wr(5, 900);
    wr_end();
    check("dup_err_pulse", 64'(load_err), 64'd1);
    @(negedge clk);
    check("dup_err_clear", 64'(load_err), 64'd0);
    for (int n = 0; n < 64; n++) if (n != 5) wr(n, 200 + 3 * n);
    wr_end();
    do_fire();
    watch(400);
    check("dup_rise5",  64'(rise[5]),  64'd1);
    check("dup_fall5",  64'(fall[5]),  64'd5);
    check("dup_rise0",  64'(rise[0]),  64'd151);
    check("dup_rise63", 64'(rise[63]), 64'd340);
    check("dup_done_k", 64'(done_k),   64'd344);
    check("dup_once",   once_vec(),    '1);

    // Missing index 40: fire is ignored until the set is complete.
    for (int n = 0; n < 64; n++) if (n != 40) wr(n, 200 + 3 * n);
    wr_end();
    check("miss_armed", 64'(armed), 64'd0);
    do_fire();
    repeat (5) @(negedge clk);
    check("miss_busy", 64'(busy),  64'd0);
    check("miss_tx",   txArray,    64'd0);
    check("miss_done", 64'(done),  64'd0);
    wr(40, 320);
    wr_end();
    check("miss_armed_now", 64'(armed), 64'd1);
    do_fire();
    watch(300);
    check("ramp_rise0",  64'(rise[0]),  64'd1);
    check("ramp_rise10", 64'(rise[10]), 64'd31);
    check("ramp_fall10", 64'(fall[10]), 64'd35);
    check("ramp_rise63", 64'(rise[63]), 64'd190);
    check("ramp_fall63", 64'(fall[63]), 64'd194);
    check("ramp_done_k", 64'(done_k),   64'd194);
    check("ramp_once",   once_vec(),    '1);

    // Reset in the middle of a transmit.
    for (int n = 0; n < 64; n++) wr(n, 200 + 3 * n);
    wr_end();
    do_fire();
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("mid_tx_active", 64'(txArray[2]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_tx",    txArray,          64'd0);
    check("mid_busy",  64'(busy),        64'd0);
    check("mid_armed", 64'(armed),       64'd0);
    check("mid_ready", 64'(load_ready),  64'd1);
    dn = 0;
    repeat (250) begin
      @(negedge clk);
      if (done || txArray != 0) dn++;
    end
    check("mid_no_done", 64'(dn), 64'd0);

`ifdef TX_APODIZATION_EN
    // Masked end elements stay quiet; timing otherwise unchanged.
    for (int n = 0; n < 64; n++) wr(n, 200 + 3 * n);
    wr_end();
    tx_mask = 64'h7FFF_FFFF_FFFF_FFFE;
    do_fire();
    tx_mask = '1;
    watch(300);
    check("apod_p0",     64'(pulses[0]),  64'd0);
    check("apod_p63",    64'(pulses[63]), 64'd0);
    check("apod_rise1",  64'(rise[1]),    64'd4);
    check("apod_rise10", 64'(rise[10]),   64'd31);
    check("apod_done_k", 64'(done_k),     64'd194);
    check("apod_once",   once_vec(),      64'h7FFF_FFFF_FFFF_FFFE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
